// File: rtl/mul_seq_nbit.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_nbit
// Description : Multi-cycle shift-add multiplier, signed/unsigned, with
//               valid/ready handshakes. Optional MUL_SEQ_EARLY_EXIT_EN
//               finishes once the remaining multiplier bits are zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_nbit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH);

    logic [1:0]           r_state;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mb;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_p;
    logic                 r_out_valid;

    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [WIDTH-1:0]     w_mb_next;
    logic [CNT_W-1:0]     w_cnt_next;
    logic                 w_last;
    logic [2*WIDTH-1:0]   w_acc_final;
    logic [2*WIDTH-1:0]   w_prod;

    assign in_ready  = (r_state == c_ST_IDLE);
    assign out_valid = r_out_valid;
    assign P         = r_p;

    // The most negative value negates to itself, which read unsigned is its magnitude.
    assign w_a_mag = (is_signed && A[WIDTH-1]) ? -A : A;
    assign w_b_mag = (is_signed && B[WIDTH-1]) ? -B : B;

    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_mb[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    assign w_mb_next  = r_mb >> 1;
    assign w_cnt_next = r_cnt + CNT_W'(1);

`ifdef MUL_SEQ_EARLY_EXIT_EN
    logic [CNT_W-1:0] w_shift;
    // Skipped iterations would only shift right, so apply them in one step.
    assign w_shift     = c_CNT_LAST - w_cnt_next;
    assign w_last      = (w_cnt_next == c_CNT_LAST) || (w_mb_next == '0);
    assign w_acc_final = w_acc_next >> w_shift;
`else
    assign w_last      = (w_cnt_next == c_CNT_LAST);
    assign w_acc_final = w_acc_next;
`endif

    assign w_prod = r_neg ? -w_acc_final : w_acc_final;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_mcand     <= '0;
            r_mb        <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_p         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_mcand <= w_a_mag;
                        r_mb    <= w_b_mag;
                        r_neg   <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    r_acc <= w_acc_next;
                    r_mb  <= w_mb_next;
                    r_cnt <= w_cnt_next;
                    if (w_last) begin
                        r_p         <= w_prod;
                        r_out_valid <= 1'b1;
                        r_state     <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_nbit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_seq_nbit
// Description : Self-checking bench for mul_seq_nbit against an arithmetic
//               reference model (honours MUL_SEQ_EARLY_EXIT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq_nbit;

    localparam int W = 8;
    typedef logic [2*W-1:0] prod_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   P;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    mul_seq_nbit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic prod_t ref_prod(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint x;
        longint y;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        return prod_t'(x * y);
    endfunction

    function automatic int ref_lat(input logic [W-1:0] b, input logic s);
`ifdef MUL_SEQ_EARLY_EXIT_EN
        logic [W-1:0] mag;
        int hi;
        mag = (s && b[W-1]) ? -b : b;
        hi  = 0;
        for (int i = 0; i < W; i++) if (mag[i]) hi = i + 1;
        return (hi == 0) ? 1 : hi;
`else
        return W;
`endif
    endfunction

    // One complete transaction with out_ready high; returns the observed product.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [2*W-1:0] p_seen);
        int g;
        int lat;
        A = a; B = b; is_signed = s; in_valid = 1'b1; out_ready = 1'b1;
        g = 0;
        while (!in_ready && g < 50) begin step(); g++; end
        check("accept_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin step(); lat++; end
        check("latency", lat, ref_lat(b, s));
        check("product", P, ref_prod(a, b, s));
        p_seen = P;
        step();
        check("ready_after_result", in_ready, 1);
    endtask

    initial begin
        logic [2*W-1:0] p;
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic           rs;
        logic           seen;
        int             g;
        int             acc_cyc;
        int             prev_lat;
        prod_t          exp_q[$];

        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; is_signed = 1'b0; out_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
        check("reset_out_valid", out_valid, 0);
        check("reset_p", P, 0);
        check("reset_in_ready", in_ready, 1);

        // Directed corner cases.
        do_op(8'hFF, 8'hFF, 1'b0, p); check("ff_x_ff", p, 16'hFE01);
        do_op(8'h80, 8'h80, 1'b1, p); check("m128_sq", p, 16'h4000);
        do_op(8'hFD, 8'h07, 1'b1, p); check("m3_x_7_s", p, 16'hFFEB);
        do_op(8'hFD, 8'h07, 1'b0, p); check("fd_x_7_u", p, 16'h06EB);
        do_op(8'h5A, 8'h01, 1'b0, p);
        do_op(8'h5A, 8'h10, 1'b0, p);
        do_op(8'h5A, 8'h00, 1'b0, p); check("b_zero_u", p, 0);
        do_op(8'hA5, 8'h00, 1'b1, p); check("b_zero_s", p, 0);
        do_op(8'h00, 8'h80, 1'b1, p); check("a_zero_s", p, 0);

        // Backpressure: result held while out_ready=0; queued operand waits.
        A = 8'd12; B = 8'd10; is_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        g = 0;
        while (!in_ready && g < 50) begin step(); g++; end
        step();
        A = 8'd3; B = 8'd5;
        g = 0;
        while (!out_valid && g < 40) begin step(); g++; end
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", out_valid, 1);
            check("stall_p", P, 120);
            check("stall_in_ready", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        check("release_p_kept", P, 120);
        step();
        check("held_operand_taken", in_ready, 0);
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 40) begin step(); g++; end
        check("held_operand_p", P, 15);
        step();

        // Reset during the 4th BUSY cycle aborts the product.
        A = 8'd9; B = 8'd9; is_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        g = 0;
        while (!in_ready && g < 50) begin step(); g++; end
        step();
        in_valid = 1'b0;
        step(); step(); step();
        rst_n = 1'b0;
        step();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_p", P, 0);
        check("midrst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid || P == 16'd81) seen = 1'b1;
            step();
        end
        check("midrst_never_81", seen, 0);

        // Random single transactions.
        for (int i = 0; i < 12; i++) begin
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom_range(0, 1));
            do_op(ra, rb, rs, p);
        end

        // Back-to-back with handshakes tied high: accept edge, latency edges,
        // then one handshake edge before the next accept.
        in_valid = 1'b1; out_ready = 1'b1;
        acc_cyc = 0; prev_lat = 0;
        for (int k = 0; k < 4; k++) begin
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom_range(0, 1));
            A = ra; B = rb; is_signed = rs;
            g = 0;
            while (!in_ready && g < 60) begin
                if (out_valid && exp_q.size() > 0) check("b2b_p", P, exp_q.pop_front());
                step(); g++;
            end
            if (k > 0) check("b2b_spacing", cyc - acc_cyc, prev_lat + 2);
            acc_cyc  = cyc;
            prev_lat = ref_lat(rb, rs);
            exp_q.push_back(ref_prod(ra, rb, rs));
            step();
        end
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 40) begin step(); g++; end
        if (exp_q.size() > 0) check("b2b_p_last", P, exp_q.pop_front());
        check("b2b_all_results", exp_q.size(), 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
